seq_mul8_ctrl: RTL and testbench

- Multi-cycle shift-and-add multiplier controller; sits directly upstream of ripple_cla16.
- Owns the adder's en/A/B/c_in inputs and consumes its Output/c_out/ready.
- Accepts two WIDTH-bit operands and produces a 2*WIDTH-bit product.
- Reuses the datapath's single 16-bit adder, so the design needs no dedicated multiplier array.

---
 rtl/mul_pkg.sv | 17 +
 rtl/seq_mul8_ctrl_if.sv | 27 ++
 rtl/seq_mul8_dp.sv | 58 +++++
 rtl/seq_mul8_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seq_mul8_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller:
// default sizing and the controller state encoding.
package mul_pkg;

    localparam int unsigned MUL_WIDTH       = 8;
    localparam int unsigned MUL_ADD_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD_WAIT,
        ADD_REL,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/seq_mul8_ctrl_if.sv
// Request/response bus of the multiplier: operands and start in,
// busy/done/err status and the product out.
interface seq_mul8_ctrl_if #(
    parameter int unsigned WIDTH = 8
);

    logic               start;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               busy;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] product;

    // Requester side
    modport master (
        output start, op_a, op_b,
        input  busy, done, err, product
    );

    // Multiplier side
    modport slave (
        input  start, op_a, op_b,
        output busy, done, err, product
    );

endinterface

// File: rtl/seq_mul8_dp.sv
// Multiplier datapath: accumulator, shifted multiplicand and multiplier
// registers with their load / capture / shift controls.
// Build option SEQ_MUL_EARLY_TERM_EN: flags when the remaining multiplier
// bits are all zero so the controller can finish early.
module seq_mul8_dp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_capture,
    input  logic               i_shift,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    input  logic [2*WIDTH-1:0] i_sum,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic               o_mplier_lsb,
    output logic               o_early_done
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    // Operand load, adder result capture and per-bit shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= (2*WIDTH)'(i_op_a);
            r_mplier <= i_op_b;
        end else begin
            if (i_capture) begin
                r_acc <= i_sum;
            end
            if (i_shift) begin
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

    assign o_acc        = r_acc;
    assign o_mcand      = r_mcand;
    assign o_mplier_lsb = r_mplier[0];

`ifdef SEQ_MUL_EARLY_TERM_EN
    // True when the multiplier will be zero after the current shift
    assign o_early_done = (r_mplier[WIDTH-1:1] == '0);
`else
    assign o_early_done = 1'b0;
`endif

endmodule

// File: rtl/seq_mul8_ctrl.sv
// Sequential shift-and-add multiplier controller. Walks the multiplier one
// bit at a time and, for each set bit, borrows the external 2*WIDTH-bit
// adder through an en/ready handshake with a one-cycle rearm gap.
// Build option SEQ_MUL_EARLY_TERM_EN: finish as soon as no multiplier bits
// remain instead of always iterating WIDTH bits.
module seq_mul8_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH       = MUL_WIDTH,
    parameter int unsigned ADD_TIMEOUT = MUL_ADD_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    seq_mul8_ctrl_if.slave     req,
    output logic               add_en,
    output logic [2*WIDTH-1:0] add_a,
    output logic [2*WIDTH-1:0] add_b,
    output logic               add_c_in,
    input  logic [2*WIDTH-1:0] add_sum,
    input  logic               add_c_out,
    input  logic               add_ready
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TMO_W = $clog2(ADD_TIMEOUT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_err;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_capture;
    logic               w_shift;
    logic               w_timeout;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_mcand;
    logic               w_mplier_lsb;
    logic               w_early_done;

    seq_mul8_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_capture    (w_capture),
        .i_shift      (w_shift),
        .i_op_a       (req.op_a),
        .i_op_b       (req.op_b),
        .i_sum        (add_sum),
        .o_acc        (w_acc),
        .o_mcand      (w_mcand),
        .o_mplier_lsb (w_mplier_lsb),
        .o_early_done (w_early_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_state_nxt = w_mplier_lsb ? ADD_WAIT : SHIFT;
            end
            ADD_WAIT: begin
                if (add_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ADD_REL;
                end else if (r_tmo_cnt == TMO_W'(ADD_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            ADD_REL: begin
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_cnt == CNT_W'(WIDTH - 1) || w_early_done) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CHECK;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit counter and per-addition timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_load) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_load || r_state == CHECK) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ADD_WAIT && !add_ready) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    // Sticky timeout flag and product register; the product is loaded on
    // entry to DONE so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_state_nxt == DONE && r_state != DONE) begin
                r_product <= w_acc;
            end
        end
    end

    assign req.busy    = (r_state != IDLE);
    assign req.done    = (r_state == DONE);
    assign req.err     = r_err;
    assign req.product = r_product;

    assign add_en   = (r_state == ADD_WAIT);
    assign add_a    = w_acc;
    assign add_b    = w_mcand;
    assign add_c_in = 1'b0;

    // Unsigned accumulation of WIDTH-bit operands never carries out
    a_no_carry_out: assert property (
        @(posedge clk) disable iff (rst) (add_en && add_ready) |-> !add_c_out
    );

endmodule

// File: tb/tb_seq_mul8_ctrl.sv
// Directed bench for seq_mul8_ctrl with a behavioural stand-in for the
// ripple_cla16 adder (fixed two-cycle latency, optional permanent stall).
module tb_seq_mul8_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        add_en;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_c_in;
    logic [15:0] add_sum;
    logic        add_c_out;
    logic        add_ready;
    logic        stall;

    int unsigned lat_cnt;
    int unsigned hs_cnt;
    int unsigned en_hi_cnt;
    int unsigned rearm_ok;
    bit          pend;

    int unsigned n_tests;
    int unsigned n_fail;

    always #5 clk = ~clk;

    seq_mul8_ctrl_if #(.WIDTH(W)) mif ();

    seq_mul8_ctrl #(
        .WIDTH       (W),
        .ADD_TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (mif.slave),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c_in  (add_c_in),
        .add_sum   (add_sum),
        .add_c_out (add_c_out),
        .add_ready (add_ready)
    );

    // Adder stand-in: ready after LAT cycles of en, rearms when en drops
    always @(posedge clk) begin
        if (rst || !add_en) lat_cnt <= 0;
        else                lat_cnt <= lat_cnt + 1;
    end
    assign add_ready = add_en && !stall && (lat_cnt == LAT - 1);
    assign {add_c_out, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_c_in};

    // Handshake monitor: handshakes, en-high cycles, rearm gap after each
    always @(negedge clk) begin
        if (!rst) begin
            if (add_en) en_hi_cnt++;
            if (pend) begin
                pend = 1'b0;
                if (!add_en) rearm_ok++;
            end
            if (add_en && add_ready) begin
                hs_cnt++;
                pend = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // mode 0: plain; 1: re-pulse start with new operands mid-run;
    // 2: hold start during the DONE cycle
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input int mode,
                           output int cyc, output logic [15:0] prod,
                           output logic e, output logic en_at_done);
        logic got;
        mif.op_a  = a;
        mif.op_b  = b;
        mif.start = 1'b1;
        @(posedge clk); #1;
        mif.start = 1'b0;
        cyc = 2;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mif.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (mode == 1 && cyc == 6) begin
                mif.op_a  = 8'd9;
                mif.op_b  = 8'd9;
                mif.start = 1'b1;
            end
            if (mode == 1 && cyc == 7) mif.start = 1'b0;
        end
        prod       = mif.product;
        e          = mif.err;
        en_at_done = add_en;
        if (!got) chk("done_wait", 32'd0, 32'd1);
        if (mode == 2) begin
            mif.start = 1'b1;
            mif.op_a  = 8'd1;
            mif.op_b  = 8'd1;
        end
        @(posedge clk); #1;
        mif.start = 1'b0;
        chk("busy_after_done", {31'd0, mif.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [15:0] prod;
        logic        e;
        logic        en_d;
        int unsigned h0, e0, r0;
        logic        saw_en;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        mif.start = 1'b0;
        mif.op_a  = '0;
        mif.op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    {31'd0, mif.busy},  32'd0);
        chk("rst_done",    {31'd0, mif.done},  32'd0);
        chk("rst_err",     {31'd0, mif.err},   32'd0);
        chk("rst_product", {16'd0, mif.product}, 32'd0);
        chk("rst_add_en",  {31'd0, add_en},    32'd0);
        chk("rst_add_a",   {16'd0, add_a},     32'd0);
        chk("rst_add_b",   {16'd0, add_b},     32'd0);
        chk("rst_c_in",    {31'd0, add_c_in},  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 127*127: seven set bits, each costing LAT+1 cycles
        h0 = hs_cnt;
        run_mul(8'd127, 8'd127, 0, cyc, prod, e, en_d);
        chk("p127_product", {16'd0, prod}, 32'd16129);
        chk("p127_err",     {31'd0, e},    32'd0);
        chk("p127_adds",    hs_cnt - h0,   32'd7);
`ifdef SEQ_MUL_EARLY_TERM_EN
        chk("p127_latency", cyc, 32'd37);
`else
        chk("p127_latency", cyc, 32'd39);
`endif

        // 255*255 with start held in the DONE cycle
        h0 = hs_cnt; e0 = en_hi_cnt; r0 = rearm_ok;
        run_mul(8'd255, 8'd255, 2, cyc, prod, e, en_d);
        chk("p255_product", {16'd0, prod},  32'd65025);
        chk("p255_adds",    hs_cnt - h0,    32'd8);
        chk("p255_rearm",   rearm_ok - r0,  32'd8);
        chk("p255_en_hi",   en_hi_cnt - e0, 32'd16);
        chk("p255_latency", cyc,            32'd42);

        // 200*0: no adder use at all
        e0 = en_hi_cnt;
        run_mul(8'd200, 8'd0, 0, cyc, prod, e, en_d);
        chk("p0_product", {16'd0, prod},  32'd0);
        chk("p0_en_hi",   en_hi_cnt - e0, 32'd0);
`ifdef SEQ_MUL_EARLY_TERM_EN
        chk("p0_latency", cyc, 32'd4);
`else
        chk("p0_latency", cyc, 32'd18);
`endif

        // Adder never ready: timeout abort with partial product
        stall = 1'b1;
        e0 = en_hi_cnt;
        run_mul(8'd5, 8'd1, 0, cyc, prod, e, en_d);
        chk("tmo_err",        {31'd0, e},     32'd1);
        chk("tmo_product",    {16'd0, prod},  32'd0);
        chk("tmo_en_hi",      en_hi_cnt - e0, 32'd64);
        chk("tmo_en_at_done", {31'd0, en_d},  32'd0);
        chk("tmo_latency",    cyc,            32'd67);
        chk("tmo_err_sticky", {31'd0, mif.err}, 32'd1);
        stall = 1'b0;
        run_mul(8'd2, 8'd3, 0, cyc, prod, e, en_d);
        chk("clr_err",     {31'd0, e},    32'd0);
        chk("clr_product", {16'd0, prod}, 32'd6);

        // Reset while an addition is pending
        mif.op_a  = 8'd11;
        mif.op_b  = 8'd13;
        mif.start = 1'b1;
        @(posedge clk); #1;
        mif.start = 1'b0;
        saw_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (add_en) begin
                saw_en = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("mid_saw_add_en", {31'd0, saw_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy",    {31'd0, mif.busy},    32'd0);
        chk("mid_rst_add_en",  {31'd0, add_en},      32'd0);
        chk("mid_rst_product", {16'd0, mif.product}, 32'd0);
        chk("mid_rst_done",    {31'd0, mif.done},    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_mul(8'd3, 8'd5, 0, cyc, prod, e, en_d);
        chk("p15_product", {16'd0, prod}, 32'd15);
        chk("p15_err",     {31'd0, e},    32'd0);

        // Start re-pulsed mid-operation is ignored
        run_mul(8'd6, 8'd7, 1, cyc, prod, e, en_d);
        chk("p42_product", {16'd0, prod}, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
